update_dispatcher: RTL and testbench

Initiator side of the update/run handshake for the arbitrage container. Buffers incoming edge updates (source, destination, weight) from the host-facing logic in a FIFO. Issues them to the container one at a time: drives `u_src`/`u_dst`/`u_e`, pulses `container_reset`, then holds the operands stable until `container_done`. Also keeps run statistics and a watchdog.

---
 rtl/update_dispatcher_if.sv | 27 ++
 rtl/update_dispatcher.sv | 128 ++++++++++++
 tb/tb_update_dispatcher.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/update_dispatcher_if.sv
// rtl/update_dispatcher_if.sv - update stream and container run handshake bundle
interface update_dispatcher_if #(
  parameter int PRED_WIDTH   = 7,
  parameter int WEIGHT_WIDTH = 15
);
  logic                  upd_valid;
  logic                  upd_ready;
  logic [PRED_WIDTH:0]   upd_src;
  logic [PRED_WIDTH:0]   upd_dst;
  logic [WEIGHT_WIDTH:0] upd_e;
  logic [PRED_WIDTH:0]   u_src;
  logic [PRED_WIDTH:0]   u_dst;
  logic [WEIGHT_WIDTH:0] u_e;
  logic                  container_reset;
  logic                  container_done;

  // master is the environment: host-side producer plus the container
  modport master (
    output upd_valid, upd_src, upd_dst, upd_e, container_done,
    input  upd_ready, u_src, u_dst, u_e, container_reset
  );

  modport slave (
    input  upd_valid, upd_src, upd_dst, upd_e, container_done,
    output upd_ready, u_src, u_dst, u_e, container_reset
  );
endinterface

// File: rtl/update_dispatcher.sv
// rtl/update_dispatcher.sv - buffers edge updates and launches them one at a time into the container
module update_dispatcher #(
  parameter int DEPTH        = 16,
  parameter int TIMEOUT      = 65535,
  parameter int PRED_WIDTH   = 7,
  parameter int WEIGHT_WIDTH = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  update_dispatcher_if.slave      bus,
  input  logic                    err_clr,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  pending,
  output logic [15:0]             runs_done,
  output logic                    timeout_err
);
  localparam int AW  = $clog2(DEPTH);
  localparam int FW  = 2 * (PRED_WIDTH + 1) + WEIGHT_WIDTH + 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT
  } state_t;

  state_t         state_q, state_d;
  logic [FW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count_q;
  logic [WDW-1:0] wd_q, wd_d;
  logic [FW-1:0]  head;
  logic           push, pop, run_ok, run_abort;

  assign bus.upd_ready = (count_q != (AW+1)'(DEPTH));
  assign push          = bus.upd_valid && bus.upd_ready;
  assign head          = mem[rd_ptr];
  assign pending       = count_q;
  assign busy          = (state_q != ST_IDLE);

  // Storage has no reset: pointers and count alone decide what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.upd_src, bus.upd_dst, bus.upd_e};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    pop       = 1'b0;
    run_ok    = 1'b0;
    run_abort = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // done is only trusted here; in LAUNCH it may still be left over from the last run
        if (bus.container_done) begin
          run_ok  = 1'b1;
          state_d = ST_IDLE;
        end else if (wd_q == WDW'(TIMEOUT)) begin
          run_abort = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= ST_IDLE;
      wd_q                <= '0;
      bus.u_src           <= '0;
      bus.u_dst           <= '0;
      bus.u_e             <= '0;
      bus.container_reset <= 1'b0;
      runs_done           <= '0;
      timeout_err         <= 1'b0;
    end else begin
      state_q             <= state_d;
      wd_q                <= wd_d;
      bus.container_reset <= (state_d == ST_LAUNCH);
      if (pop) begin
        {bus.u_src, bus.u_dst, bus.u_e} <= head;
      end
      if (run_ok) begin
        runs_done <= runs_done + 16'd1;
      end
      if (run_abort) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_update_dispatcher.sv
// tb/tb_update_dispatcher.sv - scoreboard bench for update_dispatcher
`timescale 1ns/1ps
module tb_update_dispatcher;
  localparam int PW = 7;
  localparam int WW = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  update_dispatcher_if #(.PRED_WIDTH(PW), .WEIGHT_WIDTH(WW)) bus_a ();
  update_dispatcher_if #(.PRED_WIDTH(PW), .WEIGHT_WIDTH(WW)) bus_b ();

  logic        err_clr_a, err_clr_b;
  logic        busy_a, busy_b, timeout_err_a, timeout_err_b;
  logic [4:0]  pending_a;
  logic [2:0]  pending_b;
  logic [15:0] runs_done_a, runs_done_b;

  update_dispatcher #(.DEPTH(16), .TIMEOUT(65535), .PRED_WIDTH(PW), .WEIGHT_WIDTH(WW)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .err_clr(err_clr_a), .busy(busy_a),
    .pending(pending_a), .runs_done(runs_done_a), .timeout_err(timeout_err_a)
  );

  update_dispatcher #(.DEPTH(4), .TIMEOUT(8), .PRED_WIDTH(PW), .WEIGHT_WIDTH(WW)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .err_clr(err_clr_b), .busy(busy_b),
    .pending(pending_b), .runs_done(runs_done_b), .timeout_err(timeout_err_b)
  );

  typedef struct {
    logic [7:0]  s;
    logic [7:0]  d;
    logic [15:0] e;
    int          lat;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t ea, eb;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Container models: done drops on the pulse edge, rises dly cycles later (0 = never)
  int   dly_a = 10, dly_b = 0, cnt_a = 0, cnt_b = 0;
  logic force_a = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      bus_a.container_done <= 1'b0;
      cnt_a <= 0;
    end else if (bus_a.container_reset) begin
      bus_a.container_done <= 1'b0;
      cnt_a <= dly_a;
    end else if (force_a) begin
      bus_a.container_done <= 1'b1;
    end else if (cnt_a > 0) begin
      cnt_a <= cnt_a - 1;
      if (cnt_a == 1) bus_a.container_done <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      bus_b.container_done <= 1'b0;
      cnt_b <= 0;
    end else if (bus_b.container_reset) begin
      bus_b.container_done <= 1'b0;
      cnt_b <= dly_b;
    end else if (cnt_b > 0) begin
      cnt_b <= cnt_b - 1;
      if (cnt_b == 1) bus_b.container_done <= 1'b1;
    end
  end

  logic        prev_pulse_a = 1'b0, in_run_a = 1'b0, chk_wait_a = 1'b0;
  logic        prev_pulse_b = 1'b0, in_run_b = 1'b0;
  logic [31:0] h_a, h_b;
  int          pulse_cyc_b = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_pulse_a = 1'b0;
      in_run_a     = 1'b0;
      chk_wait_a   = 1'b0;
    end else begin
      if (chk_wait_a) begin
        check("launch_to_wait_a", 32'(busy_a & ~bus_a.container_reset), 32'd1);
        chk_wait_a = 1'b0;
      end
      if (bus_a.container_reset) begin
        check("pulse_width_a", 32'(prev_pulse_a), 32'd0);
        check("pulse_expected_a", 32'(exp_a.size() != 0), 32'd1);
        if (exp_a.size() != 0) begin
          ea = exp_a.pop_front();
          check("u_src_a", 32'(bus_a.u_src), 32'(ea.s));
          check("u_dst_a", 32'(bus_a.u_dst), 32'(ea.d));
          check("u_e_a", 32'(bus_a.u_e), 32'(ea.e));
          if (ea.lat >= 0) check("launch_latency_a", 32'(cyc), 32'(ea.lat + 1));
        end
        h_a        = {bus_a.u_src, bus_a.u_dst, bus_a.u_e};
        in_run_a   = 1'b1;
        chk_wait_a = 1'b1;
      end else if (in_run_a && busy_a) begin
        check("u_stable_a", {bus_a.u_src, bus_a.u_dst, bus_a.u_e}, h_a);
      end
      prev_pulse_a = bus_a.container_reset;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_pulse_b = 1'b0;
      in_run_b     = 1'b0;
    end else begin
      if (bus_b.container_reset) begin
        check("pulse_width_b", 32'(prev_pulse_b), 32'd0);
        check("pulse_expected_b", 32'(exp_b.size() != 0), 32'd1);
        if (exp_b.size() != 0) begin
          eb = exp_b.pop_front();
          check("u_fields_b", {bus_b.u_src, bus_b.u_dst, bus_b.u_e}, {eb.s, eb.d, eb.e});
        end
        h_b         = {bus_b.u_src, bus_b.u_dst, bus_b.u_e};
        in_run_b    = 1'b1;
        pulse_cyc_b = cyc;
      end else if (in_run_b && busy_b) begin
        check("u_stable_b", {bus_b.u_src, bus_b.u_dst, bus_b.u_e}, h_b);
      end
      prev_pulse_b = bus_b.container_reset;
    end
  end

  task automatic push_a(input logic [7:0] s, input logic [7:0] d, input logic [15:0] e, input bit lat);
    int  n = 0;
    bit  acc = 1'b0;
    bus_a.upd_valid = 1'b1;
    bus_a.upd_src   = s;
    bus_a.upd_dst   = d;
    bus_a.upd_e     = e;
    while (!acc && n < 200) begin
      acc = bus_a.upd_ready;
      tick(1);
      n++;
    end
    bus_a.upd_valid = 1'b0;
    if (acc) exp_a.push_back('{s, d, e, lat ? cyc : -1});
    check("push_accept_a", 32'(acc), 32'd1);
  endtask

  task automatic push_b(input logic [7:0] s, input logic [7:0] d, input logic [15:0] e);
    int  n = 0;
    bit  acc = 1'b0;
    bus_b.upd_valid = 1'b1;
    bus_b.upd_src   = s;
    bus_b.upd_dst   = d;
    bus_b.upd_e     = e;
    while (!acc && n < 200) begin
      acc = bus_b.upd_ready;
      tick(1);
      n++;
    end
    bus_b.upd_valid = 1'b0;
    if (acc) exp_b.push_back('{s, d, e, -1});
    check("push_accept_b", 32'(acc), 32'd1);
  endtask

  task automatic wait_idle_a(input int lim);
    int n = 0;
    while ((busy_a || pending_a != 0) && n < lim) begin
      tick(1);
      n++;
    end
    check("idle_reached_a", 32'(!busy_a && pending_a == 0), 32'd1);
  endtask

  task automatic check_reset_a();
    check("rst_upd_ready", 32'(bus_a.upd_ready), 32'd1);
    check("rst_u_fields", {bus_a.u_src, bus_a.u_dst, bus_a.u_e}, 32'd0);
    check("rst_container_reset", 32'(bus_a.container_reset), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_pending", 32'(pending_a), 32'd0);
    check("rst_runs_done", 32'(runs_done_a), 32'd0);
    check("rst_timeout_err", 32'(timeout_err_a), 32'd0);
  endtask

  initial begin
    int n;
    bus_a.upd_valid = 1'b0; bus_a.upd_src = '0; bus_a.upd_dst = '0; bus_a.upd_e = '0;
    bus_b.upd_valid = 1'b0; bus_b.upd_src = '0; bus_b.upd_dst = '0; bus_b.upd_e = '0;
    err_clr_a = 1'b0;
    err_clr_b = 1'b0;
    reset = 1'b1;
    tick(3);
    check_reset_a();
    check("rst_b_state", {busy_b, timeout_err_b, pending_b, runs_done_b}, 32'd0);
    reset = 1'b0;
    tick(1);

    // Watchdog: first run never completes, second is queued behind it
    dly_b = 0;
    push_b(8'h11, 8'h22, 16'h0033);
    push_b(8'h44, 8'h55, 16'h0066);
    n = 0;
    while (!timeout_err_b && n < 100) begin
      tick(1);
      n++;
    end
    dly_b = 3;
    check("timeout_seen", 32'(timeout_err_b), 32'd1);
    check("timeout_cycles", 32'(cyc - pulse_cyc_b), 32'd10);
    check("timeout_runs_done", 32'(runs_done_b), 32'd0);
    check("timeout_pending", 32'(pending_b), 32'd1);
    n = 0;
    while ((busy_b || pending_b != 0) && n < 100) begin
      tick(1);
      n++;
    end
    check("wd_next_run_done", 32'(runs_done_b), 32'd1);
    check("timeout_sticky", 32'(timeout_err_b), 32'd1);
    err_clr_b = 1'b1;
    tick(1);
    err_clr_b = 1'b0;
    check("err_clr", 32'(timeout_err_b), 32'd0);

    // Single update, done 10 cycles after the pulse
    dly_a = 10;
    push_a(8'd3, 8'd5, 16'h0040, 1'b1);
    wait_idle_a(100);
    check("single_runs_done", 32'(runs_done_a), 32'd1);
    check("single_busy", 32'(busy_a), 32'd0);

    // Back-to-back: second push coincides with the first pop
    dly_a = 4;
    push_a(8'h01, 8'h02, 16'h0100, 1'b1);
    push_a(8'h06, 8'h07, 16'h02AB, 1'b0);
    check("push_pop_same_cycle", 32'(pending_a), 32'd1);
    push_a(8'h7E, 8'h0F, 16'hFFFF, 1'b0);
    wait_idle_a(200);
    check("b2b_runs_done", 32'(runs_done_a), 32'd4);

    // Full FIFO behind a blocked run
    dly_a = 0;
    push_a(8'h0A, 8'h0B, 16'h000C, 1'b0);
    tick(2);
    for (int i = 0; i < 16; i++) push_a(8'(i), 8'(i + 16), 16'h1000 + 16'(i), 1'b0);
    check("full_pending", 32'(pending_a), 32'd16);
    check("full_upd_ready", 32'(bus_a.upd_ready), 32'd0);
    fork
      push_a(8'h7F, 8'h70, 16'hBEEF, 1'b0);
      begin
        tick(4);
        check("stall_pending", 32'(pending_a), 32'd16);
        dly_a = 2;
        force_a = 1'b1;
        tick(1);
        force_a = 1'b0;
      end
    join
    check("refill_pending", 32'(pending_a), 32'd16);
    wait_idle_a(2000);
    check("full_runs_done", 32'(runs_done_a), 32'd22);

    // Reset in WAIT with four entries queued
    dly_a = 0;
    for (int i = 0; i < 5; i++) push_a(8'(8'h20 + i), 8'(8'h30 + i), 16'h2000 + 16'(i), 1'b0);
    check("pre_reset_pending", 32'(pending_a), 32'd4);
    tick(5);
    reset = 1'b1;
    exp_a.delete();
    tick(1);
    reset = 1'b0;
    check_reset_a();
    tick(20);
    check("post_reset_quiet", {busy_a, pending_a}, 32'd0);
    dly_a = 3;
    push_a(8'h44, 8'h55, 16'h0066, 1'b1);
    wait_idle_a(100);
    check("post_reset_runs_done", 32'(runs_done_a), 32'd1);

    tick(2);
    check("exp_a_drained", 32'(exp_a.size()), 32'd0);
    check("exp_b_drained", 32'(exp_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
